// File: rtl/time_sync_pkg.sv
// Shared types and constants for the time-sync arbiter.
//   TS_W / PKT_W : timestamp and packet widths
//   ts_pkt_t     : {payload, timestamp} packet layout
//   ofs_t        : default-width per-channel offset type
//   state_t      : output-slot state (EMPTY / FULL)
package time_sync_pkg;

    localparam int TS_W      = 64;
    localparam int PKT_W     = 128;
    localparam int OFS_W_DEF = 16;

    typedef struct packed {
        logic [63:0] payload;
        logic [63:0] ts;
    } ts_pkt_t;

    typedef logic [OFS_W_DEF-1:0] ofs_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Timestamp correction; wraps modulo 2^64 without any flag.
    function automatic logic [TS_W-1:0] ts_adjust(input logic [TS_W-1:0] ts,
                                                  input logic [TS_W-1:0] ofs_ext);
        return ts + ofs_ext;
    endfunction

endpackage

// File: rtl/time_sync_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req   : request vector, one bit per channel
//   last  : channel granted most recently (scan starts at last+1)
//   grant : one-hot grant
//   idx   : encoded index of the granted channel
//   any   : at least one request present
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    // Scan last+1, last+2, ... modulo NUM_CH and keep the first hit.
    always_comb begin : p_scan
        logic [CH_W-1:0] c;
        c     = '0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = CH_W'((int'(last) + i) % NUM_CH);
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = c;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/time_sync_arbiter.sv
// time_sync_arbiter: round-robin sharing of one timestamp-offset path between
// NUM_CH sensor streams, feeding a single valid/ready output register.
//   clk, rst            : clock, synchronous active-high reset
//   req_data/valid/ready: per-channel 128-bit packets {payload, ts}
//   cfg_we/ch/offset    : per-channel offset programming
//   ref_time            : reference time for the lateness flag
//   out_*               : registered output slot (data, channel, flags)
// Optional: define TS_MONO_CHECK_EN to build per-channel timestamp
// regression detection driving out_mono_err; otherwise it is tied to 0.
module time_sync_arbiter
    import time_sync_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  OFS_W  = 16,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*PKT_W-1:0] req_data,
    input  logic [NUM_CH-1:0]       req_valid,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [OFS_W-1:0]        cfg_offset,
    input  logic [TS_W-1:0]         ref_time,
    output logic [PKT_W-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_late,
    output logic                    out_mono_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    state_t              state_r, state_n;
    logic [CH_W-1:0]     last_grant_r;
    logic [OFS_W-1:0]    ofs_r [NUM_CH];
    logic [NUM_CH-1:0]   grant_s;
    logic [CH_W-1:0]     idx_s;
    logic                any_s;
    logic                slot_free_s;
    logic                capture_s;
    logic                cfg_hit_s;
    ts_pkt_t             sel_pkt_s;
    logic [TS_W-1:0]     adjusted_s;
    logic                late_s;
    logic                mono_s;

    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
        .req   (req_valid),
        .last  (last_grant_r),
        .grant (grant_s),
        .idx   (idx_s),
        .any   (any_s)
    );

    assign slot_free_s = (state_r == ST_EMPTY) || out_ready;
    assign capture_s   = slot_free_s && any_s && !rst;
    assign cfg_hit_s   = cfg_we && ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
    assign out_valid   = (state_r == ST_FULL);

    // Accept strobe: only the granted channel, only when the slot can take it.
    always_comb begin
        req_ready = '0;
        if (capture_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Packet mux and timestamp correction for the granted channel.
    always_comb begin
        sel_pkt_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx_s == CH_W'(i)) begin
                sel_pkt_s = req_data[i*PKT_W +: PKT_W];
            end else begin
                sel_pkt_s = sel_pkt_s;
            end
        end
    end

    assign adjusted_s = ts_adjust(sel_pkt_s.ts, {{(TS_W-OFS_W){1'b0}}, ofs_r[idx_s]});
    assign late_s     = (adjusted_s < ref_time);

    // Output-slot next state.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (capture_s) state_n = ST_FULL;
                else           state_n = ST_EMPTY;
            end
            ST_FULL: begin
                if (out_ready && !capture_s) state_n = ST_EMPTY;
                else                         state_n = ST_FULL;
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    // State, arbitration pointer and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_EMPTY;
            last_grant_r <= CH_W'(NUM_CH - 1);
            out_data     <= '0;
            out_ch       <= '0;
            out_late     <= 1'b0;
        end else begin
            state_r <= state_n;
            if (capture_s) begin
                last_grant_r <= idx_s;
                out_data     <= {sel_pkt_s.payload, adjusted_s};
                out_ch       <= idx_s;
                out_late     <= late_s;
            end
        end
    end

    // Offset table; a same-cycle capture reads the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) ofs_r[i] <= '0;
        end else if (cfg_hit_s) begin
            ofs_r[cfg_ch] <= cfg_offset;
        end
    end

`ifdef TS_MONO_CHECK_EN
    logic [TS_W-1:0]   last_ts_r [NUM_CH];
    logic [NUM_CH-1:0] seen_r;

    assign mono_s = seen_r[idx_s] && (adjusted_s < last_ts_r[idx_s]);

    // Per-channel history; reprogramming a channel restarts its history,
    // taking precedence over a capture in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_r       <= '0;
            out_mono_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) last_ts_r[i] <= '0;
        end else begin
            if (capture_s) begin
                last_ts_r[idx_s] <= adjusted_s;
                seen_r[idx_s]    <= 1'b1;
                out_mono_err     <= mono_s;
            end
            if (cfg_hit_s) begin
                seen_r[cfg_ch] <= 1'b0;
            end
        end
    end
`else
    assign mono_s       = 1'b0;
    assign out_mono_err = mono_s;
`endif

endmodule

// File: tb/tb_time_sync_arbiter.sv
module tb_time_sync_arbiter;
    import time_sync_pkg::*;

    localparam int NUM_CH = 4;
    localparam int OFS_W  = 16;
    localparam int CH_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH*PKT_W-1:0] req_data;
    logic [NUM_CH-1:0]       req_valid;
    logic [NUM_CH-1:0]       req_ready;
    logic                    cfg_we;
    logic [CH_W-1:0]         cfg_ch;
    logic [OFS_W-1:0]        cfg_offset;
    logic [63:0]             ref_time;
    logic [127:0]            out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_late;
    logic                    out_mono_err;
    logic                    out_valid;
    logic                    out_ready;

    time_sync_arbiter #(.NUM_CH(NUM_CH), .OFS_W(OFS_W)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_ready(req_ready), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_offset(cfg_offset), .ref_time(ref_time), .out_data(out_data),
        .out_ch(out_ch), .out_late(out_late), .out_mono_err(out_mono_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  valid;
        logic        ordy;
        logic        cwe;
        logic [1:0]  cch;
        logic [15:0] coff;
        logic [63:0] tsb;
        logic [63:0] rt;
        logic [3:0]  exp_ready;
    } vec_t;

    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   ch;
        logic         late;
        logic         mono;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic [15:0] m_ofs [4];
`ifdef TS_MONO_CHECK_EN
    logic [63:0] m_last [4];
    logic [3:0]  m_seen;
`endif
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic add(input string name, input logic [3:0] valid, input logic ordy,
                       input logic cwe, input logic [1:0] cch, input logic [15:0] coff,
                       input logic [63:0] tsb, input logic [63:0] rt, input logic [3:0] exp_ready);
        vec_t v;
        v.name = name; v.valid = valid; v.ordy = ordy; v.cwe = cwe; v.cch = cch;
        v.coff = coff; v.tsb = tsb; v.rt = rt; v.exp_ready = exp_ready;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 4; i++) m_ofs[i] = 16'h0;
`ifdef TS_MONO_CHECK_EN
        for (int i = 0; i < 4; i++) m_last[i] = 64'h0;
        m_seen = 4'h0;
`endif
    endtask

    // One cycle: drive at negedge, check just after, update the scoreboard.
    task automatic step(input vec_t v);
        exp_t        e;
        int          g;
        logic [63:0] adj;
        @(negedge clk);
        req_valid  = v.valid;
        out_ready  = v.ordy;
        cfg_we     = v.cwe;
        cfg_ch     = v.cch;
        cfg_offset = v.coff;
        ref_time   = v.rt;
        for (int i = 0; i < NUM_CH; i++)
            req_data[i*128 +: 128] = {32'hC0DE_0000, 32'(i), v.tsb + 64'(i) * 64'h10};
        #1;
        chk({v.name, " req_ready"}, 128'(req_ready), 128'(v.exp_ready));
        chk({v.name, " out_valid"}, 128'(out_valid), 128'(sb.size() != 0));
        if (sb.size() != 0) begin
            e = sb[0];
            chk({v.name, " out_data"}, out_data, e.data);
            chk({v.name, " out_ch"}, 128'(out_ch), 128'(e.ch));
            chk({v.name, " out_late"}, 128'(out_late), 128'(e.late));
            chk({v.name, " out_mono_err"}, 128'(out_mono_err), 128'(e.mono));
            if (v.ordy) void'(sb.pop_front());
        end
        if (v.exp_ready != 4'h0) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (v.exp_ready[i]) g = i;
            adj    = v.tsb + 64'(g) * 64'h10 + {48'h0, m_ofs[g]};
            e.data = {32'hC0DE_0000, 32'(g), adj};
            e.ch   = 2'(g);
            e.late = (adj < v.rt);
`ifdef TS_MONO_CHECK_EN
            e.mono    = m_seen[g] && (adj < m_last[g]);
            m_last[g] = adj;
            m_seen[g] = 1'b1;
`else
            e.mono = 1'b0;
`endif
            sb.push_back(e);
        end
        if (v.cwe) begin
            m_ofs[v.cch] = v.coff;
`ifdef TS_MONO_CHECK_EN
            m_seen[v.cch] = 1'b0;
`endif
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'hF; out_ready = 1'b1; cfg_we = 1'b0;
        cfg_ch = 2'd0; cfg_offset = 16'h0; ref_time = 64'h0; req_data = '0;
        model_reset();

        // Reset: no accepts while in reset, output slot cleared.
        @(negedge clk); #1;
        chk("rst req_ready", 128'(req_ready), 128'h0);
        @(negedge clk); #1;
        chk("rst out_valid", 128'(out_valid), 128'h0);
        chk("rst out_data", out_data, 128'h0);
        chk("rst out_ch", 128'(out_ch), 128'h0);
        chk("rst out_late", 128'(out_late), 128'h0);
        chk("rst out_mono_err", 128'(out_mono_err), 128'h0);
        req_valid = 4'h0;
        rst = 1'b0;

        //   name      valid   ordy cwe  cch   coff      tsb                     ref      exp
        add("cfg2",   4'h0,   1'b1, 1'b1, 2'd2, 16'h10, 64'h0,                  64'h0,   4'h0);
        add("single", 4'b0100,1'b1, 1'b0, 2'd0, 16'h0,  64'hE0,                 64'h50,  4'b0100);
        add("drain1", 4'h0,   1'b1, 1'b0, 2'd0, 16'h0,  64'h0,                  64'h0,   4'h0);
        add("rr0",    4'hF,   1'b1, 1'b0, 2'd0, 16'h0,  64'h1000,               64'h0,   4'b1000);
        add("rr1",    4'hF,   1'b1, 1'b0, 2'd0, 16'h0,  64'h1000,               64'h0,   4'b0001);
        add("rr2",    4'hF,   1'b1, 1'b0, 2'd0, 16'h0,  64'h1000,               64'h0,   4'b0010);
        add("rr3",    4'hF,   1'b1, 1'b0, 2'd0, 16'h0,  64'h1000,               64'h0,   4'b0100);
        add("rr4",    4'hF,   1'b1, 1'b0, 2'd0, 16'h0,  64'h1000,               64'h0,   4'b1000);
        add("rr5",    4'hF,   1'b1, 1'b0, 2'd0, 16'h0,  64'h1000,               64'h0,   4'b0001);
        add("rr6",    4'hF,   1'b1, 1'b0, 2'd0, 16'h0,  64'h1000,               64'h0,   4'b0010);
        add("rr7",    4'hF,   1'b1, 1'b0, 2'd0, 16'h0,  64'h1000,               64'h0,   4'b0100);
        for (int i = 0; i < 5; i++)
            add($sformatf("hold%0d", i), 4'b1010, 1'b0, 1'b0, 2'd0, 16'h0, 64'h2000, 64'h0, 4'h0);
        add("resume3",4'b1010,1'b1, 1'b0, 2'd0, 16'h0,  64'h2000,               64'h0,   4'b1000);
        add("resume1",4'b1010,1'b1, 1'b0, 2'd0, 16'h0,  64'h2000,               64'h0,   4'b0010);
        add("drain2", 4'h0,   1'b1, 1'b0, 2'd0, 16'h0,  64'h0,                  64'h0,   4'h0);
        add("idle2",  4'h0,   1'b1, 1'b0, 2'd0, 16'h0,  64'h0,                  64'h0,   4'h0);
        add("cfg1",   4'h0,   1'b1, 1'b1, 2'd1, 16'h10, 64'h0,                  64'h0,   4'h0);
        add("wrap",   4'b0010,1'b1, 1'b0, 2'd0, 16'h0,  64'hFFFF_FFFF_FFFF_FFE8,64'h20,  4'b0010);
        add("drain3", 4'h0,   1'b1, 1'b0, 2'd0, 16'h0,  64'h0,                  64'h0,   4'h0);
        add("cfg0a",  4'h0,   1'b1, 1'b1, 2'd0, 16'h1,  64'h0,                  64'h0,   4'h0);
        add("coll",   4'b0001,1'b1, 1'b1, 2'd0, 16'h5,  64'h3000,               64'h0,   4'b0001);
        add("after",  4'b0001,1'b1, 1'b0, 2'd0, 16'h0,  64'h3100,               64'h0,   4'b0001);
        add("drain4", 4'h0,   1'b1, 1'b0, 2'd0, 16'h0,  64'h0,                  64'h0,   4'h0);
        add("cfg1z",  4'h0,   1'b1, 1'b1, 2'd1, 16'h0,  64'h0,                  64'h0,   4'h0);
        add("mono_a", 4'b0010,1'b1, 1'b0, 2'd0, 16'h0,  64'h1F0,                64'h0,   4'b0010);
        add("mono_b", 4'b0010,1'b1, 1'b0, 2'd0, 16'h0,  64'h1E0,                64'h0,   4'b0010);
        add("drain5", 4'h0,   1'b1, 1'b0, 2'd0, 16'h0,  64'h0,                  64'h0,   4'h0);
        add("idle5",  4'h0,   1'b1, 1'b0, 2'd0, 16'h0,  64'h0,                  64'h0,   4'h0);
        add("pre_rst",4'b0001,1'b0, 1'b0, 2'd0, 16'h0,  64'h4000,               64'h0,   4'b0001);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Reset while a packet is held: it is dropped, offsets and pointer restart.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst req_ready", 128'(req_ready), 128'h0);
        @(negedge clk); #1;
        chk("midrst out_valid", 128'(out_valid), 128'h0);
        chk("midrst out_data", out_data, 128'h0);
        rst = 1'b0;
        req_valid = 4'h0;
        model_reset();
        vecs.delete();
        add("post0",  4'b0101,1'b1, 1'b0, 2'd0, 16'h0,  64'h300,                64'h0,   4'b0001);
        add("post1",  4'b0101,1'b1, 1'b0, 2'd0, 16'h0,  64'h300,                64'h0,   4'b0100);
        add("drain6", 4'h0,   1'b1, 1'b0, 2'd0, 16'h0,  64'h0,                  64'h0,   4'h0);
        add("idle6",  4'h0,   1'b1, 1'b0, 2'd0, 16'h0,  64'h0,                  64'h0,   4'h0);
        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
